// File: rtl/ser2par8_if.sv
// ============================================================================
// Module   : ser2par8_if
// Brief    : Serial-in / parallel-out handshake bundle for ser2par8.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ser2par8_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Ser_In;
  logic             Ser_Valid;
  logic             Clr_Ovr;
  logic [WIDTH-1:0] Par_Out;
  logic             EN_Out;
  logic             Busy;
  logic             Ovr;

  modport master (
    output Start,
    output Ser_In,
    output Ser_Valid,
    output Clr_Ovr,
    input  Par_Out,
    input  EN_Out,
    input  Busy,
    input  Ovr
  );

  modport slave (
    input  Start,
    input  Ser_In,
    input  Ser_Valid,
    input  Clr_Ovr,
    output Par_Out,
    output EN_Out,
    output Busy,
    output Ovr
  );
endinterface

`default_nettype wire

// File: rtl/ser2par8.sv
// ============================================================================
// Module   : ser2par8
// Brief    : Frames serial bits into a WIDTH-bit word and strobes a load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ser2par8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic clk,
  input  wire logic res,
  ser2par8_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;

  // Shift direction decides where the first received bit ends up.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_q[WIDTH-2:0], bus.Ser_In};
    end else begin : g_lsb_first
      assign shifted = {bus.Ser_In, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    ovr_d   = ovr_q;

    if (bus.Clr_Ovr) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        // A start request mid-frame is flagged; set overrides clear.
        if (bus.Start) begin
          ovr_d = 1'b1;
        end
        if (bus.Ser_Valid) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = LOAD;
            par_d   = shifted;
          end
        end
      end
      LOAD: begin
        if (bus.Start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d   = (state_d == LOAD);
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.Par_Out = par_q;
  assign bus.EN_Out  = en_q;
  assign bus.Busy    = busy_q;
  assign bus.Ovr     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_ser2par8.sv
// ============================================================================
// Module   : tb_ser2par8
// Brief    : Directed + random bench for ser2par8 (both bit orders).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ser2par8;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic start = 1'b0, ser_in = 1'b0, ser_valid = 1'b0, clr_ovr = 1'b0;

  int total = 0;
  int bad   = 0;
  int en_cnt_m = 0;
  int en_cnt_l = 0;

  // Reference model: frame in progress + received-bit queue.
  bit       m_in_frame = 1'b0;
  bit       m_bits[$];
  bit [7:0] m_par_m = 8'h00;
  bit [7:0] m_par_l = 8'h00;
  bit       m_en = 1'b0;
  bit       m_ovr = 1'b0;

  ser2par8_if #(.WIDTH(8)) if_m ();
  ser2par8_if #(.WIDTH(8)) if_l ();

  assign if_m.Start = start;  assign if_m.Ser_In = ser_in;
  assign if_m.Ser_Valid = ser_valid;  assign if_m.Clr_Ovr = clr_ovr;
  assign if_l.Start = start;  assign if_l.Ser_In = ser_in;
  assign if_l.Ser_Valid = ser_valid;  assign if_l.Clr_Ovr = clr_ovr;

  ser2par8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .res(res), .bus(if_m.slave));
  ser2par8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .res(res), .bus(if_l.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [7:0] wm, wl;
    if (res) begin
      m_in_frame = 1'b0; m_bits.delete(); m_par_m = 8'h00; m_par_l = 8'h00;
      m_en = 1'b0; m_ovr = 1'b0;
    end else begin
      if (m_in_frame && start) m_ovr = 1'b1;
      else if (clr_ovr)        m_ovr = 1'b0;
      m_en = 1'b0;
      if (m_in_frame) begin
        if (ser_valid) begin
          m_bits.push_back(ser_in);
          if (m_bits.size() == 8) begin
            wm = 8'h00; wl = 8'h00;
            for (int i = 0; i < 8; i++) begin
              wm = wm | (8'(m_bits[i]) << (7 - i));
              wl = wl | (8'(m_bits[i]) << i);
            end
            m_par_m = wm; m_par_l = wl; m_en = 1'b1;
            m_in_frame = 1'b0; m_bits.delete();
          end
        end
      end else if (start) begin
        m_in_frame = 1'b1; m_bits.delete();
      end
    end
  endtask

  // One clock: drive inputs, advance, update model, compare all outputs.
  task automatic cyc(input bit st, input bit si, input bit sv, input bit clr, input bit rs);
    start = st; ser_in = si; ser_valid = sv; clr_ovr = clr; res = rs;
    @(posedge clk);
    model_edge();
    #1;
    chk("msb_par",  32'(if_m.Par_Out), 32'(m_par_m));
    chk("msb_en",   32'(if_m.EN_Out),  32'(m_en));
    chk("msb_busy", 32'(if_m.Busy),    32'(m_in_frame));
    chk("msb_ovr",  32'(if_m.Ovr),     32'(m_ovr));
    chk("lsb_par",  32'(if_l.Par_Out), 32'(m_par_l));
    chk("lsb_en",   32'(if_l.EN_Out),  32'(m_en));
    chk("lsb_busy", 32'(if_l.Busy),    32'(m_in_frame));
    chk("lsb_ovr",  32'(if_l.Ovr),     32'(m_ovr));
    if (if_m.EN_Out === 1'b1) en_cnt_m++;
    if (if_l.EN_Out === 1'b1) en_cnt_l++;
  endtask

  // Start cycle then 8 bits, first bit = w[7]; optional gap after bit gap_at.
  task automatic send_frame(input bit [7:0] w, input int gap_at, input int gap_len,
                            input bit gap_start, input bit gap_clr);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, w[7-i], 1'b1, 1'b0, 1'b0);
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc(gap_start && (g == 0), 1'b0, 1'b0, gap_clr && (g == 0), 1'b0);
          chk("gap_busy", 32'(if_m.Busy), 32'd1);
        end
      end
    end
  endtask

  initial begin
    int e0;
    // Reset for two edges with random side inputs.
    for (int i = 0; i < 2; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    chk("rst_par",  32'(if_m.Par_Out), 32'h00);
    chk("rst_en",   32'(if_m.EN_Out),  32'd0);
    chk("rst_busy", 32'(if_m.Busy),    32'd0);
    chk("rst_ovr",  32'(if_m.Ovr),     32'd0);

    // Basic frame 0,1,1,1,0,1,1,1.
    e0 = en_cnt_m;
    send_frame(8'h77, -1, 0, 1'b0, 1'b0);
    chk("f77_par", 32'(if_m.Par_Out), 32'h77);
    chk("f77_lsb_par", 32'(if_l.Par_Out), 32'hEE);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    chk("f77_pulses", 32'(en_cnt_m - e0), 32'd1);
    chk("f77_busy", 32'(if_m.Busy), 32'd0);
    chk("f77_hold", 32'(if_m.Par_Out), 32'h77);

    // Gap of 3 idle cycles after bit 3.
    e0 = en_cnt_m;
    send_frame(8'hA5, 3, 3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_pulses", 32'(en_cnt_m - e0), 32'd1);
    chk("a5_par", 32'(if_m.Par_Out), 32'hA5);

    // Overrun during frame, then clear, then clear+set together.
    send_frame(8'h3C, 2, 1, 1'b1, 1'b0);
    chk("3c_ovr", 32'(if_m.Ovr), 32'd1);
    chk("3c_par", 32'(if_m.Par_Out), 32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovr", 32'(if_m.Ovr), 32'd0);
    send_frame(8'h5A, 1, 1, 1'b1, 1'b1);
    chk("setwins_ovr", 32'(if_m.Ovr), 32'd1);
    chk("5a_par", 32'(if_m.Par_Out), 32'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after 5 bits discards the frame.
    e0 = en_cnt_m;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("midrst_pulses", 32'(en_cnt_m - e0), 32'd0);
    chk("midrst_par", 32'(if_m.Par_Out), 32'h00);
    send_frame(8'hC3, -1, 0, 1'b0, 1'b0);
    chk("c3_par", 32'(if_m.Par_Out), 32'hC3);

    // Back-to-back: next Start lands in the LOAD cycle.
    e0 = en_cnt_m;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, -1, 0, 1'b0, 1'b0);
    start = 1'b1; ser_valid = 1'b0; res = 1'b0; clr_ovr = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_busy", 32'(if_m.Busy), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("b2b_par", 32'(if_m.Par_Out), 32'h00);
    chk("b2b_pulses", 32'(en_cnt_m - e0), 32'd2);

    // LSB-first ordering: bits 1,1,1,0,1,1,1,0 -> 8'h77.
    send_frame(8'hEE, -1, 0, 1'b0, 1'b0);
    chk("lsb_order_par", 32'(if_l.Par_Out), 32'h77);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 8) == 0, 1'($urandom), ($urandom % 4) != 0,
          ($urandom % 16) == 0, ($urandom % 64) == 0);
    chk("rand_pulses_agree", 32'(en_cnt_l), 32'(en_cnt_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ser2par8.md
SER2PAR8 -- requirements
Module: ser2par8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in Par_Out[WIDTH-1], 0 = first bit lands in Par_Out[0].
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  frame start request, sampled on the rising edge.
REQ-006 Ser_In  input  1  serial data bit.
REQ-007 Ser_Valid  input  1  Ser_In is valid this cycle.
REQ-008 Clr_Ovr  input  1  clears the sticky overrun flag.
REQ-009 Par_Out  output  WIDTH  assembled word; drives the downstream register's Reg_In.
REQ-010 EN_Out  output  1  single-cycle load strobe; drives the downstream register's EN.
REQ-011 Busy  output  1  high while a frame is being shifted in.
REQ-012 Ovr  output  1  sticky overrun flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and LOAD.
REQ-014 In IDLE, Start=1 SHALL move the FSM to SHIFT, clear the bit counter and clear the shift register; Ser_Valid SHALL be ignored in IDLE.
REQ-015 In SHIFT, each edge with Ser_Valid=1 SHALL shift Ser_In into the shift register per MSB_FIRST and increment the bit counter.
REQ-016 In SHIFT, an edge with Ser_Valid=0 SHALL hold the shift register and counter unchanged; gaps have unlimited length.
REQ-017 The edge that samples bit WIDTH-1 SHALL move the FSM to LOAD, register the complete word into Par_Out and set EN_Out=1.
REQ-018 EN_Out SHALL be high for exactly the one cycle the FSM spends in LOAD; Par_Out becomes valid in that same cycle (latency: 1 edge after the last bit is sampled).
REQ-019 Par_Out SHALL hold its value between loads; it changes only at a LOAD entry or at reset.
REQ-020 From LOAD, the FSM SHALL go to SHIFT if Start=1 (back-to-back frame, counter and shift register cleared) and to IDLE otherwise.
REQ-021 Busy SHALL be 1 exactly when the FSM is in SHIFT.
REQ-022 Start=1 while in SHIFT SHALL NOT disturb the current frame and SHALL set Ovr=1.
REQ-023 Ovr SHALL remain set until an edge with Clr_Ovr=1; if Clr_Ovr and an overrun set event occur on the same edge, the set SHALL win.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap within a frame.

Reset
REQ-025 res=1 on an edge SHALL force: FSM=IDLE, counter=0, shift register=0, Par_Out=0, EN_Out=0, Busy=0, Ovr=0; reset takes priority over all other inputs.
REQ-026 A reset in the middle of a frame SHALL discard the partial word; no EN_Out pulse SHALL be produced for that frame.
REQ-027 Outputs SHALL be directly registered, with no combinational path from inputs to outputs.

Verification
REQ-028 Reset: res=1 for 2 edges with random other inputs -> Par_Out=8'h00, EN_Out=0, Busy=0, Ovr=0.
REQ-029 Frame: Start, then 8 valid bits 0,1,1,1,0,1,1,1 (MSB_FIRST=1) -> one EN_Out pulse with Par_Out=8'h77; Busy=0 afterwards; Par_Out still 8'h77 10 cycles later.
REQ-030 Gaps: frame 8'hA5 with Ser_Valid=0 for 3 cycles after bit 3 -> Busy held at 1 through the gap, single EN_Out pulse, Par_Out=8'hA5.
REQ-031 Overrun: Start pulsed after bit 2 of frame 8'h3C -> Ovr=1, Par_Out=8'h3C; Clr_Ovr=1 -> Ovr=0; Clr_Ovr plus a new overrun on the same edge -> Ovr=1.
REQ-032 Reset mid-frame: res=1 after bit 4 -> no EN_Out pulse, Par_Out=8'h00; a following frame 8'hC3 loads correctly.
REQ-033 Back-to-back and ordering: Start high during the LOAD cycle -> second frame 8'h00 accepted with no IDLE cycle between frames; with MSB_FIRST=0, bits 1,1,1,0,1,1,1,0 -> Par_Out=8'h77.
